// File: rtl/cpu_regfile_pkg.sv
// Shared definitions for the CPU register file read port: default geometry,
// named register indices and the output-stage state encoding.
package cpu_regfile_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_S0   = 5'd16;
    localparam logic [4:0] REG_S1   = 5'd17;
    localparam logic [4:0] REG_S2   = 5'd18;
    localparam logic [4:0] REG_S3   = 5'd19;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Operand selection for one read port: hardwired zero, then same-cycle
// writeback bypass, then the stored array value.
module regfile_bypass_mux
    import cpu_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] operand
);

    always_comb begin
        operand = mem_data;
        if (idx == ADDR_W'(REG_ZERO)) begin
            operand = '0;
        end else if (wr_en && (wr_addr == idx)) begin
            operand = wr_data;
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// Register file with a one-entry response stage: writes are always honored,
// reads are accepted over valid/ready and answered one cycle later.
module regfile_read_port
    import cpu_regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] writeData,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              rspValid,
    input  logic              rspReady,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2
);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
    logic              capture;
    rsp_state_e        state;
    rsp_state_e        state_next;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (regWrite && (rd != ADDR_W'(REG_ZERO))) begin
            mem[rd] <= writeData;
        end
    end

    regfile_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mux_rs (
        .idx      (rs),
        .mem_data (mem[rs]),
        .wr_en    (regWrite),
        .wr_addr  (rd),
        .wr_data  (writeData),
        .operand  (operand1)
    );

    regfile_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mux_rt (
        .idx      (rt),
        .mem_data (mem[rt]),
        .wr_en    (regWrite),
        .wr_addr  (rd),
        .wr_data  (writeData),
        .operand  (operand2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // reqReady deliberately ignores reqValid so the handshake has no comb loop.
    always_comb begin
        state_next = state;
        rspValid   = 1'b0;
        reqReady   = 1'b1;
        capture    = 1'b0;
        unique case (state)
            EMPTY: begin
                if (reqValid) begin
                    capture    = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                rspValid = 1'b1;
                reqReady = rspReady;
                if (rspReady) begin
                    if (reqValid) begin
                        capture = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Captured operands are a snapshot; later writes only reach the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readData1 <= '0;
            readData2 <= '0;
        end else if (capture) begin
            readData1 <= operand1;
            readData2 <= operand2;
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// Randomized and directed bench for regfile_read_port with a transaction-level
// reference model of the register array and the single pending response.
module tb_regfile_read_port;

    logic        clk;
    logic        rst_n;
    logic        regWrite;
    logic [4:0]  rd;
    logic [31:0] writeData;
    logic        reqValid;
    logic        reqReady;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] readData1;
    logic [31:0] readData2;

    int n_vec;
    int n_err;

    logic [31:0] m_mem [32];
    logic        m_valid;
    logic [31:0] m_d1;
    logic [31:0] m_d2;

    regfile_read_port #(
        .NUM_REGS (32),
        .DATA_W   (32),
        .ADDR_W   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .regWrite  (regWrite),
        .rd        (rd),
        .writeData (writeData),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .rs        (rs),
        .rt        (rt),
        .rspValid  (rspValid),
        .rspReady  (rspReady),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        m_valid = 1'b0;
        m_d1    = 32'h0;
        m_d2    = 32'h0;
    endtask

    function automatic logic [31:0] model_operand(input int x);
        if (x == 0) return 32'h0;
        if (regWrite && (int'(rd) == x)) return writeData;
        return m_mem[x];
    endfunction

    // One clock cycle with the currently driven inputs; model follows the edge.
    task automatic tick();
        logic        acc;
        logic [31:0] o1;
        logic [31:0] o2;
        acc = reqValid && (!m_valid || rspReady);
        o1  = model_operand(int'(rs));
        o2  = model_operand(int'(rt));
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_d1    = o1;
            m_d2    = o2;
        end else if (m_valid && rspReady) begin
            m_valid = 1'b0;
        end
        if (regWrite && rd != 5'd0) m_mem[rd] = writeData;
        #1;
    endtask

    task automatic idle_inputs();
        regWrite  = 1'b0;
        rd        = 5'd0;
        writeData = 32'h0;
        reqValid  = 1'b0;
        rs        = 5'd0;
        rt        = 5'd0;
        rspReady  = 1'b1;
    endtask

    task automatic drain();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        n_vec++;
        if (rspValid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rspValid got %0b want 0", rspValid);
        end
        n_vec++;
        if (reqReady !== 1'b1) begin
            n_err++;
            $display("FAIL reset_reqReady got %0b want 1", reqReady);
        end
        n_vec++;
        if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data got %h/%h want 0/0", readData1, readData2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        idle_inputs();
        regWrite = 1'b1; rd = 5'd16; writeData = 32'hDEADBEEF;
        tick();
        idle_inputs();
        reqValid = 1'b1; rs = 5'd16; rt = 5'd0;
        tick();
        reqValid = 1'b0;
        n_vec++;
        if (rspValid !== 1'b1 || readData1 !== 32'hDEADBEEF || readData2 !== 32'h0) begin
            n_err++;
            $display("FAIL write_read got v=%0b %h/%h want v=1 deadbeef/00000000",
                     rspValid, readData1, readData2);
        end
        drain();
    endtask

    task automatic test_bypass();
        idle_inputs();
        regWrite = 1'b1; rd = 5'd17; writeData = 32'h12345678;
        reqValid = 1'b1; rs = 5'd17; rt = 5'd17;
        tick();
        idle_inputs();
        n_vec++;
        if (rspValid !== 1'b1 || readData1 !== 32'h12345678 || readData2 !== 32'h12345678) begin
            n_err++;
            $display("FAIL bypass got v=%0b %h/%h want v=1 12345678/12345678",
                     rspValid, readData1, readData2);
        end
        drain();
    endtask

    task automatic test_zero_write();
        idle_inputs();
        regWrite = 1'b1; rd = 5'd0; writeData = 32'hFFFFFFFF;
        reqValid = 1'b1; rs = 5'd0; rt = 5'd0;
        tick();
        n_vec++;
        if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
            n_err++;
            $display("FAIL zero_bypass got %h/%h want 0/0", readData1, readData2);
        end
        regWrite = 1'b0;
        tick();
        n_vec++;
        if (rspValid !== 1'b1 || readData1 !== 32'h0) begin
            n_err++;
            $display("FAIL zero_read got v=%0b %h want v=1 00000000", rspValid, readData1);
        end
        drain();
    endtask

    task automatic test_backpressure();
        idle_inputs();
        regWrite = 1'b1; rd = 5'd18; writeData = 32'hA5;
        tick();
        regWrite = 1'b1; rd = 5'd19; writeData = 32'hC0FFEE00;
        tick();
        idle_inputs();
        reqValid = 1'b1; rs = 5'd18; rt = 5'd0; rspReady = 1'b0;
        tick();
        regWrite = 1'b1; rd = 5'd18; writeData = 32'h5A;
        rs = 5'd19; rt = 5'd18;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (reqReady !== 1'b0) begin
                n_err++;
                $display("FAIL bp_reqReady cycle %0d got %0b want 0", c, reqReady);
            end
            tick();
            regWrite = 1'b0;
            n_vec++;
            if (rspValid !== 1'b1 || readData1 !== 32'hA5) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d got v=%0b %h want v=1 000000a5",
                         c, rspValid, readData1);
            end
        end
        rspReady = 1'b1;
        #1;
        n_vec++;
        if (reqReady !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready got %0b want 1", reqReady);
        end
        tick();
        n_vec++;
        if (rspValid !== 1'b1 || readData1 !== 32'hC0FFEE00 || readData2 !== 32'h5A) begin
            n_err++;
            $display("FAIL bp_new_accept got v=%0b %h/%h want v=1 c0ffee00/0000005a",
                     rspValid, readData1, readData2);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            vals[i]   = $urandom;
            regWrite  = 1'b1;
            rd        = 5'(16 + i);
            writeData = vals[i];
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            reqValid = 1'b1;
            rs       = 5'(16 + i);
            rt       = 5'(19 - i);
            tick();
            n_vec++;
            if (rspValid !== 1'b1 || readData1 !== vals[i] || readData2 !== vals[3 - i]) begin
                n_err++;
                $display("FAIL b2b_%0d got v=%0b %h/%h want v=1 %h/%h",
                         i, rspValid, readData1, readData2, vals[i], vals[3 - i]);
            end
        end
        reqValid = 1'b0;
        tick();
        n_vec++;
        if (rspValid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain got v=%0b want 0", rspValid);
        end
        drain();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        regWrite = 1'b1; rd = 5'd16; writeData = 32'h0BADF00D;
        tick();
        idle_inputs();
        reqValid = 1'b1; rs = 5'd16; rt = 5'd16; rspReady = 1'b0;
        tick();
        reqValid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (rspValid !== 1'b0 || readData1 !== 32'h0 || readData2 !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset got v=%0b %h/%h want v=0 0/0",
                     rspValid, readData1, readData2);
        end
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        reqValid = 1'b1; rs = 5'd16; rt = 5'd0;
        tick();
        reqValid = 1'b0;
        n_vec++;
        if (rspValid !== 1'b1 || readData1 !== 32'h0) begin
            n_err++;
            $display("FAIL post_reset_read got v=%0b %h want v=1 00000000", rspValid, readData1);
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            regWrite  = ($urandom_range(0, 1) == 1);
            rd        = 5'($urandom_range(0, 31));
            writeData = $urandom;
            reqValid  = ($urandom_range(0, 3) != 0);
            rs        = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 31));
            rt        = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rspReady  = ($urandom_range(0, 2) != 0);
            #1;
            n_vec++;
            if (reqReady !== (!m_valid || rspReady)) begin
                n_err++;
                $display("FAIL rand_reqReady cycle %0d got %0b want %0b",
                         c, reqReady, (!m_valid || rspReady));
            end
            tick();
            n_vec++;
            if (rspValid !== m_valid) begin
                n_err++;
                $display("FAIL rand_rspValid cycle %0d got %0b want %0b", c, rspValid, m_valid);
            end else if (m_valid && (readData1 !== m_d1 || readData2 !== m_d2)) begin
                n_err++;
                $display("FAIL rand_data cycle %0d got %h/%h want %h/%h",
                         c, readData1, readData2, m_d1, m_d2);
            end
        end
        drain();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_write();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
